des_key_schedule: RTL and testbench

//  Generates the 16 DES 48-bit round subkeys from a 64-bit key, one per accepted handshake, for the round datapath

---
 rtl/des_key_schedule.sv | 168 ++++++++++++++++
 tb/tb_des_key_schedule.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// des_key_schedule: on-the-fly DES round-key generator (PC-1, C/D rotate, PC-2), encrypt or decrypt order.
// Define KEY_PARITY_CHK_EN to reject keys containing an even-parity byte (parity_err), otherwise parity_err is 0.
//
// state | meaning
// IDLE  | waiting for a key, key_ready=1
// RUN   | issuing subkeys, sk_valid=1
// DONE  | one-cycle sched_done pulse, then IDLE
module des_key_schedule #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        sched_done,
  output logic        parity_err
);

  if (ROUNDS != 16) begin : g_rounds_chk
    $error("des_key_schedule: ROUNDS must be 16");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  // Tables use DES bit numbering: bit 1 is key_in[63] / the MSB of C.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (0-based index).
  function automatic logic shift_two(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d, round_nx;
  logic        dec_q, dec_d;
  logic        perr_q, perr_d;
  logic [55:0] cd_load;
  logic        key_ok;

  assign cd_load = pc1(key_in);

`ifdef KEY_PARITY_CHK_EN
  logic [7:0] byte_odd;
  always_comb begin
    byte_odd = '0;
    for (int b = 0; b < 8; b++) byte_odd[b] = ^key_in[8*b +: 8];
  end
  assign key_ok = &byte_odd;
`else
  assign key_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    round_d  = round_q;
    dec_d    = dec_q;
    perr_d   = perr_q;
    round_nx = round_q + 4'd1;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          perr_d = !key_ok;
          if (key_ok) begin
            state_d = ST_RUN;
            dec_d   = decrypt;
            round_d = '0;
            // Decrypt starts at C16D16, which equals C0D0 after the full 28-bit wrap.
            if (decrypt) begin
              {c_d, d_d} = cd_load;
            end else begin
              c_d = rot_l(cd_load[55:28], 1'b0);
              d_d = rot_l(cd_load[27:0], 1'b0);
            end
          end
        end
      end
      ST_RUN: begin
        if (sk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_nx;
            if (dec_q) begin
              c_d = rot_r(c_q, shift_two(4'd15 - round_q));
              d_d = rot_r(d_q, shift_two(4'd15 - round_q));
            end else begin
              c_d = rot_l(c_q, shift_two(round_nx));
              d_d = rot_l(d_q, shift_two(round_nx));
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      perr_q  <= perr_d;
    end
  end

  assign key_ready  = (state_q == ST_IDLE);
  assign sk_valid   = (state_q == ST_RUN);
  assign sched_done = (state_q == ST_DONE);
  assign sk_round   = round_q;
  assign subkey     = sk_valid ? pc2({c_q, d_q}) : '0;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: reference DES key schedule feeds a scoreboard of expected subkeys.
// Parity rejection is exercised when KEY_PARITY_CHK_EN is defined for both bench and design.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic [3:0]  sk_round;
  logic        sk_valid;
  logic        sk_ready;
  logic        sched_done;
  logic        parity_err;

  des_key_schedule #(.ROUNDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .decrypt    (decrypt),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .subkey     (subkey),
    .sk_round   (sk_round),
    .sk_valid   (sk_valid),
    .sk_ready   (sk_ready),
    .sched_done (sched_done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;
  localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  bit acc_live = 0;
  bit mon_en = 0;
  bit exp_perr = 0;
  bit known_en = 0;
  logic [47:0] known_first, known_last;
  logic [51:0] sb [$];
  logic [51:0] e;
  bit          prev_valid = 0, prev_ready = 0;
  logic [47:0] prev_sub;
  logic [3:0]  prev_rnd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round n key (1..16) from the cumulative left shift of C0/D0.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int rnd);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k;
    int sh;
    sh = 0;
    for (int i = 1; i <= rnd; i++) sh += ((i == 1) || (i == 2) || (i == 9) || (i == 16)) ? 1 : 2;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1_T[i]];
      d[27-i] = key[64-PC1_T[28+i]];
    end
    for (int s = 0; s < sh; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    k = '0;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
    return k;
  endfunction

  function automatic bit parity_bad(input logic [63:0] k);
    bit bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) bad = 1'b1;
`ifndef KEY_PARITY_CHK_EN
    bad = 1'b0;
`endif
    return bad;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("parity_err", {63'd0, parity_err}, {63'd0, exp_perr});
      if (!rst_n) begin
        sb.delete();
        exp_perr   = 1'b0;
        acc_live   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          chk("stall_subkey", subkey, prev_sub);
          chk("stall_round", sk_round, prev_rnd);
        end
        if (acc_live && cyc == acc_cyc + 1) begin
          chk("first_latency", sk_valid, 1);
          if (known_en) chk("known_first", subkey, known_first);
        end
        if (key_valid && sk_valid) chk("busy_key_ready", key_ready, 0);
        if (sk_valid && sk_ready) begin
          if (sb.size() == 0) begin
            chk("extra_subkey", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("sk_round", sk_round, e[51:48]);
            chk("subkey", subkey, e[47:0]);
            if (known_en && sk_round == 4'd15) chk("known_last", subkey, known_last);
          end
        end
        if (sched_done) begin
          done_cnt++;
          chk("done_sk_valid", sk_valid, 0);
          chk("done_key_ready", key_ready, 0);
          chk("done_queue_empty", sb.size(), 0);
          if (known_en) chk("done_latency", cyc - acc_cyc, 17);
        end
        if (key_valid && key_ready) begin
          exp_perr = parity_bad(key_in);
          if (!exp_perr) begin
            for (int j = 0; j < 16; j++)
              sb.push_back({4'(j), ref_subkey(key_in, decrypt ? 16 - j : j + 1)});
            acc_cyc  = cyc;
            acc_live = 1'b1;
          end
        end
        prev_valid = sk_valid;
        prev_ready = sk_ready;
        prev_sub   = subkey;
        prev_rnd   = sk_round;
      end
    end
  end

  // mode 0: sk_ready high, 1: random stalls + 5-cycle stall at round 7,
  // 2: new key offered during RUN, 3: reset at round 9
  task automatic run_sched(input logic [63:0] key, input logic dec, input int mode, input bit known);
    int budget, stall7, d0;
    known_en = known;
    known_first = dec ? K16_STD : K1_STD;
    known_last  = dec ? K1_STD : K16_STD;
    d0 = done_cnt;
    stall7 = 0;
    budget = 0;
    key_in = key;
    decrypt = dec;
    key_valid = 1'b1;
    sk_ready = (mode != 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = ~dec;
    while (done_cnt == d0 && budget < 400) begin
      case (mode)
        1: begin
          if (sk_valid && sk_round == 4'd7 && stall7 < 5) begin
            sk_ready = 1'b0;
            stall7++;
          end else begin
            sk_ready = 1'($urandom_range(0, 1));
          end
        end
        2: begin
          if (sk_valid && sk_round >= 4'd4 && sk_round <= 4'd6) begin
            key_valid = 1'b1;
            key_in = 64'h0123456789ABCDEF;
            decrypt = ~dec;
          end else begin
            key_valid = 1'b0;
          end
        end
        3: begin
          if (sk_valid && sk_round == 4'd9) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_sk_valid", sk_valid, 0);
            chk("rst_key_ready", key_ready, 1);
            chk("rst_sched_done", sched_done, 0);
            break;
          end
        end
        default: ;
      endcase
      @(posedge clk); #1;
      budget++;
    end
    key_valid = 1'b0;
    sk_ready = 1'b1;
    if (mode == 3) begin
      repeat (6) begin
        @(posedge clk); #1;
      end
      chk("rst_no_done", done_cnt, d0);
    end else if (done_cnt == d0) begin
      chk("schedule_timeout", 0, 1);
    end
    known_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_in = '0;
    decrypt = 1'b0;
    key_valid = 1'b0;
    sk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_key_ready", key_ready, 1);
    chk("reset_sk_valid", sk_valid, 0);
    chk("reset_sk_round", sk_round, 0);
    chk("reset_subkey", subkey, 0);
    chk("reset_sched_done", sched_done, 0);
    chk("reset_parity_err", parity_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("release_key_ready", key_ready, 1);
    @(posedge clk); #1;

    run_sched(KEY_STD, 1'b0, 0, 1'b1);
    chk("idle_after_done", key_ready, 1);
    run_sched(KEY_STD, 1'b1, 0, 1'b1);
    run_sched(KEY_STD, 1'b0, 1, 1'b0);
    run_sched(KEY_STD, 1'b1, 1, 1'b0);
    run_sched(KEY_STD, 1'b0, 2, 1'b0);
    run_sched(KEY_STD, 1'b0, 3, 1'b0);
    run_sched(KEY_STD, 1'b0, 0, 1'b1);
    for (int t = 0; t < 3; t++)
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, 1'b0);

`ifdef KEY_PARITY_CHK_EN
    key_in = KEY_BAD;
    decrypt = 1'b0;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(negedge clk);
    chk("perr_set", parity_err, 1);
    chk("perr_key_ready", key_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("perr_no_subkey", sk_valid, 0);
    end
    @(posedge clk); #1;
`else
    run_sched(KEY_BAD, 1'b0, 0, 1'b0);
`endif
    run_sched(KEY_STD, 1'b0, 0, 1'b1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
